// File: rtl/scaler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scaler_pkg
// Description : Shared constants for the requantisation stage and its
//               neighbours.
// Revision    : 1.0 - initial release
// ============================================================================
package scaler_pkg;

    localparam int c_factor_width = 32;

    // A full-width product can never overflow.
    function automatic int prod_width(input int result_width);
        return result_width + c_factor_width;
    endfunction

endpackage : scaler_pkg
`default_nettype wire

// File: rtl/scaler_index_counter.sv
`default_nettype none
// ============================================================================
// Module      : scaler_index_counter
// Description : Modulo-CELL_AMOUNT cell index counter with enable.
// Revision    : 1.0 - initial release
// ============================================================================
module scaler_index_counter
    import scaler_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int CELL_AMOUNT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_enable,
    output logic [DATA_WIDTH-1:0] o_index
);

    localparam logic [DATA_WIDTH-1:0] c_last = DATA_WIDTH'(CELL_AMOUNT - 1);

    logic [DATA_WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= (r_count == c_last) ? '0 : r_count + DATA_WIDTH'(1);
        end
    end

    assign o_index = r_count;

endmodule : scaler_index_counter
`default_nettype wire

// File: rtl/scaler.sv
`default_nettype none
// ============================================================================
// Module      : scaler
// Description : Multiply / shift / saturate requantiser with rotating cell
//               index tag and a single registered output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module scaler
    import scaler_pkg::*;
#(
    parameter int          DATA_WIDTH     = 8,
    parameter int          RESULT_WIDTH   = 16,
    parameter logic [31:0] SCALING_FACTOR = 32'd10,
    parameter int          SHIFT_AMOUNT   = 1,
    parameter int          CELL_AMOUNT    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [RESULT_WIDTH:0] input_result,
    output logic [DATA_WIDTH-1:0] output_value,
    output logic [DATA_WIDTH-1:0] output_index,
    output logic                  output_enable
);

    localparam int c_prod_width = prod_width(RESULT_WIDTH);

    logic                    w_valid;
    logic [c_prod_width-1:0] w_product;
    logic [c_prod_width-1:0] w_shifted;
    logic [DATA_WIDTH-1:0]   w_saturated;
    logic [DATA_WIDTH-1:0]   w_index;

    logic [DATA_WIDTH-1:0]   r_value;
    logic [DATA_WIDTH-1:0]   r_index;
    logic                    r_enable;

    assign w_valid   = input_result[RESULT_WIDTH];
    assign w_product = c_prod_width'(input_result[RESULT_WIDTH-1:0])
                     * c_prod_width'(SCALING_FACTOR);
    assign w_shifted = w_product >> SHIFT_AMOUNT;

    // Any set bit above the output width means the value exceeds full scale.
    assign w_saturated = (|w_shifted[c_prod_width-1:DATA_WIDTH])
                       ? {DATA_WIDTH{1'b1}}
                       : w_shifted[DATA_WIDTH-1:0];

    scaler_index_counter #(
        .DATA_WIDTH  (DATA_WIDTH),
        .CELL_AMOUNT (CELL_AMOUNT)
    ) u_index_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_enable (w_valid),
        .o_index  (w_index)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value  <= '0;
            r_index  <= '0;
            r_enable <= 1'b0;
        end else if (w_valid) begin
            r_value  <= w_saturated;
            r_index  <= w_index;
            r_enable <= 1'b1;
        end else begin
            r_value  <= '0;
            r_index  <= '0;
            r_enable <= 1'b0;
        end
    end

    assign output_value  = r_value;
    assign output_index  = r_index;
    assign output_enable = r_enable;

endmodule : scaler
`default_nettype wire

// File: tb/tb_scaler.sv
`default_nettype none
// ============================================================================
// Module      : tb_scaler
// Description : Scoreboard bench for scaler, default and swept parameter sets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scaler;

    typedef struct {
        int unsigned value;
        int unsigned index;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [16:0] input_result;

    logic [7:0]  val_a, idx_a, val_b, idx_b;
    logic        en_a, en_b;

    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    int   n_valid_a = 0;
    int   n_valid_b = 0;

    scaler dut_a (
        .clk           (clk),
        .rst_n         (rst_n),
        .input_result  (input_result),
        .output_value  (val_a),
        .output_index  (idx_a),
        .output_enable (en_a)
    );

    scaler #(
        .DATA_WIDTH     (8),
        .RESULT_WIDTH   (16),
        .SCALING_FACTOR (32'd1),
        .SHIFT_AMOUNT   (0),
        .CELL_AMOUNT    (3)
    ) dut_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .input_result  (input_result),
        .output_value  (val_b),
        .output_index  (idx_b),
        .output_enable (en_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned ref_value(input longint unsigned r,
                                              input longint unsigned factor,
                                              input int shift);
        longint unsigned s;
        s = (r * factor) >> shift;
        return (s > 255) ? 255 : int'(s);
    endfunction

    task automatic check(input string name, input int unsigned got,
                         input int unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic mon_one(input string tag, input logic en,
                           input logic [7:0] val, input logic [7:0] idx,
                           input bit which_b);
        exp_t e;
        if (en === 1'b1) begin
            if ((which_b ? q_b.size() : q_a.size()) == 0) begin
                check({tag, " unexpected enable"}, 1, 0);
            end else begin
                e = which_b ? q_b.pop_front() : q_a.pop_front();
                check({tag, " value"}, val, e.value);
                check({tag, " index"}, idx, e.index);
            end
        end else begin
            check({tag, " idle enable"}, en, 0);
            check({tag, " idle value"}, val, 0);
            check({tag, " idle index"}, idx, 0);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_one("a", en_a, val_a, idx_a, 1'b0);
            mon_one("b", en_b, val_b, idx_b, 1'b1);
        end
    end

    task automatic drive(input bit v, input int unsigned r);
        exp_t e;
        input_result = {v, 16'(r)};
        if (v) begin
            e.value = ref_value(r, 10, 1);
            e.index = n_valid_a % 2;
            q_a.push_back(e);
            n_valid_a++;
            e.value = ref_value(r, 1, 0);
            e.index = n_valid_b % 3;
            q_b.push_back(e);
            n_valid_b++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_cleared(input string name);
        check({name, " a enable"}, en_a, 0);
        check({name, " a value"}, val_a, 0);
        check({name, " a index"}, idx_a, 0);
        check({name, " b enable"}, en_b, 0);
        check({name, " b index"}, idx_b, 0);
    endtask

    // Reset lands between edges; anything not yet shown is discarded.
    task automatic mid_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_cleared("async reset");
        q_a.delete();
        q_b.delete();
        n_valid_a = 0;
        n_valid_b = 0;
        input_result = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        input_result = '0;
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        mon_en = 1'b1;
        check_cleared("power-on reset");
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset held");
        rst_n = 1'b1;

        drive(0, 1);
        drive(1, 1);
        drive(1, 5);
        drive(1, 0);
        drive(1, 3);
        drive(0, 60);
        drive(1, 52);
        drive(1, 65535);
        drive(1, 9);
        drive(0, 0);
        drive(0, 77);
        drive(1, 11);
        repeat (5) drive(1, 7);
        drive(1, 2);
        mid_reset();
        drive(1, 4);
        drive(1, 6);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0)
                drive(1'b0, $urandom_range(0, 65535));
            else if ($urandom_range(0, 1) == 0)
                drive(1'b1, $urandom_range(0, 60));
            else
                drive(1'b1, $urandom_range(0, 65535));
            if (i == 200) mid_reset();
        end

        drive(0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("a pending at end", q_a.size(), 0);
        check("b pending at end", q_b.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_scaler
`default_nettype wire
